// File: rtl/rename_pkg.sv
// Shared rename-stage definitions used by the free list, RAT/regfile and ROB.
package rename_pkg;

    localparam int NUM_PHYS = 256;
    localparam int NUM_ARCH = 32;
    localparam int WIDTH    = 4;
    localparam int TAG_W    = 8;

    typedef logic [TAG_W-1:0] phys_tag_t;

    // Tags 0..NUM_ARCH-1 start mapped, so the free list holds the rest in order.
    function automatic phys_tag_t reset_tag(input int unsigned idx);
        phys_tag_t tag;
        if (idx < NUM_PHYS - NUM_ARCH) begin
            tag = phys_tag_t'(idx + NUM_ARCH);
        end else begin
            tag = 8'd0;
        end
        return tag;
    endfunction

endpackage

// File: rtl/phys_free_list_popcount_prefix.sv
// Exclusive prefix population counts of a 4-bit slot mask, plus the total.
module popcount_prefix (
    input  logic [3:0]      mask,
    output logic [3:0][2:0] prefix,
    output logic [2:0]      total
);

    logic [2:0] sum_s;

    // Running sum across slots: slot k sees the count of set bits below it.
    always_comb begin
        sum_s  = 3'd0;
        prefix = '0;
        for (int k = 0; k < 4; k++) begin
            prefix[k] = sum_s;
            sum_s     = sum_s + {2'b00, mask[k]};
        end
        total = sum_s;
    end

endmodule

// File: rtl/phys_free_list.sv
// Circular free list of physical tags with speculative and committed heads.
module phys_free_list
    import rename_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        alloc_valid,
    input  logic [3:0]  alloc_req,
    output logic [31:0] alloc_tags,
    output logic        alloc_ready,
    input  logic [3:0]  commit_en,
    input  logic [3:0]  free_en,
    input  logic [31:0] free_tags,
    input  logic        bp_reset,
    output logic [8:0]  free_count,
    output logic        overflow_err
);

    phys_tag_t mem_q [0:NUM_PHYS-1];
    phys_tag_t mem_d [0:NUM_PHYS-1];
    phys_tag_t spec_head_q, spec_head_d;
    phys_tag_t commit_head_q, commit_head_d;
    phys_tag_t tail_q, tail_d;
    logic      overflow_q, overflow_d;

    logic [3:0][2:0] alloc_pre_s;
    logic [3:0][2:0] free_pre_s;
    logic [2:0]      alloc_tot_s, commit_tot_s, free_tot_s;
    logic            fire_s;
    logic            commit_err_s, free_err_s;
    phys_tag_t       spec_dist_s;
    logic [8:0]      held_s;

    popcount_prefix u_alloc_pc  (.mask(alloc_req), .prefix(alloc_pre_s), .total(alloc_tot_s));
    popcount_prefix u_commit_pc (.mask(commit_en), .prefix(),            .total(commit_tot_s));
    popcount_prefix u_free_pc   (.mask(free_en),   .prefix(free_pre_s),  .total(free_tot_s));

    assign free_count   = {1'b0, phys_tag_t'(tail_q - spec_head_q)};
    assign alloc_ready  = (free_count >= 9'd4);
    assign overflow_err = overflow_q;
    assign fire_s       = alloc_valid & alloc_ready & ~bp_reset;

    // Compacted tag read from the speculative head; reads old contents, no bypass.
    always_comb begin
        alloc_tags = 32'd0;
        for (int k = 0; k < WIDTH; k++) begin
            if (alloc_req[k]) begin
                alloc_tags[8*k +: 8] = mem_q[phys_tag_t'(spec_head_q + phys_tag_t'(alloc_pre_s[k]))];
            end else begin
                alloc_tags[8*k +: 8] = 8'd0;
            end
        end
    end

    // Next-state for pointers, free-slot writes and the sticky error.
    always_comb begin
        mem_d = mem_q;
        for (int k = 0; k < WIDTH; k++) begin
            if (free_en[k]) begin
                mem_d[phys_tag_t'(tail_q + phys_tag_t'(free_pre_s[k]))] = free_tags[8*k +: 8];
            end else begin
                mem_d[phys_tag_t'(tail_q + phys_tag_t'(free_pre_s[k]))] =
                    mem_q[phys_tag_t'(tail_q + phys_tag_t'(free_pre_s[k]))];
            end
        end

        tail_d        = tail_q + phys_tag_t'(free_tot_s);
        commit_head_d = commit_head_q + phys_tag_t'(commit_tot_s);

        // A flush rewinds to the head as it stands after this cycle's commits.
        if (bp_reset) begin
            spec_head_d = commit_head_d;
        end else if (fire_s) begin
            spec_head_d = spec_head_q + phys_tag_t'(alloc_tot_s);
        end else begin
            spec_head_d = spec_head_q;
        end

        spec_dist_s  = spec_head_q - commit_head_q;
        commit_err_s = (phys_tag_t'(commit_tot_s) > spec_dist_s);
        held_s       = {1'b0, phys_tag_t'(tail_q - commit_head_q)} + {6'd0, free_tot_s};
        free_err_s   = (held_s > 9'(NUM_PHYS - NUM_ARCH));
        overflow_d   = overflow_q | commit_err_s | free_err_s;
    end

    // State registers with asynchronous reset to the initial mapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PHYS; i++) begin
                mem_q[i] <= reset_tag(i);
            end
            spec_head_q   <= 8'd0;
            commit_head_q <= 8'd0;
            tail_q        <= 8'(NUM_PHYS - NUM_ARCH);
            overflow_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PHYS; i++) begin
                mem_q[i] <= mem_d[i];
            end
            spec_head_q   <= spec_head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
            overflow_q    <= overflow_d;
        end
    end

endmodule

// File: tb/tb_phys_free_list.sv
// Directed bench for phys_free_list with hand-computed expectations.
module tb_phys_free_list;

    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_valid;
    logic [3:0]  alloc_req;
    logic [31:0] alloc_tags;
    logic        alloc_ready;
    logic [3:0]  commit_en;
    logic [3:0]  free_en;
    logic [31:0] free_tags;
    logic        bp_reset;
    logic [8:0]  free_count;
    logic        overflow_err;

    int checks = 0;
    int errors = 0;

    phys_free_list dut (
        .clk(clk), .reset(reset), .alloc_valid(alloc_valid), .alloc_req(alloc_req),
        .alloc_tags(alloc_tags), .alloc_ready(alloc_ready), .commit_en(commit_en),
        .free_en(free_en), .free_tags(free_tags), .bp_reset(bp_reset),
        .free_count(free_count), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        alloc_valid = 1'b0; alloc_req = 4'd0; commit_en = 4'd0;
        free_en = 4'd0; free_tags = 32'd0; bp_reset = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
    endtask

    task automatic alloc_groups(input int n);
        alloc_valid = 1'b1; alloc_req = 4'b1111;
        for (int i = 0; i < n; i++) tick();
        idle();
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #3;
        chk("rst_free_count", 32'(free_count), 32'd224);
        chk("rst_ready", 32'(alloc_ready), 32'd1);
        chk("rst_overflow", 32'(overflow_err), 32'd0);
        chk("rst_tags", alloc_tags, 32'd0);
        #4;
        reset = 1'b0;
        tick();

        // Full group from reset
        alloc_valid = 1'b1; alloc_req = 4'b1111;
        #1;
        chk("grp4_tags", alloc_tags, 32'h23222120);
        tick();
        idle();
        #1;
        chk("grp4_count", 32'(free_count), 32'd220);

        // Sparse request compaction, then the next allocation continues at 34
        do_reset();
        alloc_valid = 1'b1; alloc_req = 4'b1010;
        #1;
        chk("sparse_tags", alloc_tags, 32'h21002000);
        tick();
        alloc_req = 4'b0001;
        #1;
        chk("sparse_count", 32'(free_count), 32'd222);
        chk("sparse_next", alloc_tags, 32'h00000022);
        idle();

        // Drain to empty, stalled requests, then a single free
        do_reset();
        alloc_groups(56);
        chk("empty_count", 32'(free_count), 32'd0);
        chk("empty_ready", 32'(alloc_ready), 32'd0);
        alloc_valid = 1'b1; alloc_req = 4'b1111;
        tick(); tick();
        idle();
        #1;
        chk("empty_stall_count", 32'(free_count), 32'd0);
        free_en = 4'b0001; free_tags = 32'h00000007;
        tick();
        idle();
        #1;
        chk("one_free_count", 32'(free_count), 32'd1);
        chk("one_free_ready", 32'(alloc_ready), 32'd0);
        chk("one_free_overflow", 32'(overflow_err), 32'd1);

        // Commit two, then flush back to the committed head
        do_reset();
        alloc_groups(2);
        chk("pre_flush_count", 32'(free_count), 32'd216);
        commit_en = 4'b0011;
        tick();
        idle();
        bp_reset = 1'b1;
        alloc_valid = 1'b1; alloc_req = 4'b1111;
        tick();
        idle();
        #1;
        chk("flush_count", 32'(free_count), 32'd222);
        alloc_valid = 1'b1; alloc_req = 4'b0001;
        #1;
        chk("flush_next_tag", alloc_tags, 32'h00000022);
        chk("flush_overflow", 32'(overflow_err), 32'd0);
        idle();

        // Recycle tags 0..3 behind the last original tag 255
        do_reset();
        alloc_groups(55);
        alloc_valid = 1'b1; alloc_req = 4'b1111;
        #1;
        chk("last_orig_tags", alloc_tags, 32'hFFFEFDFC);
        tick();
        idle();
        commit_en = 4'b1111;
        tick();
        idle();
        free_en = 4'b1111; free_tags = 32'h03020100;
        tick();
        idle();
        #1;
        chk("recycle_count", 32'(free_count), 32'd4);
        chk("recycle_ready", 32'(alloc_ready), 32'd1);
        alloc_valid = 1'b1; alloc_req = 4'b1111;
        #1;
        chk("recycle_tags", alloc_tags, 32'h03020100);
        tick();
        idle();
        #1;
        chk("recycle_after_count", 32'(free_count), 32'd0);
        chk("recycle_overflow", 32'(overflow_err), 32'd0);

        // Freeing into a full list is an overflow, sticky until reset
        do_reset();
        free_en = 4'b0001; free_tags = 32'h00000005;
        tick();
        idle();
        #1;
        chk("ovf_set", 32'(overflow_err), 32'd1);
        chk("ovf_count", 32'(free_count), 32'd225);
        tick(); tick();
        chk("ovf_sticky", 32'(overflow_err), 32'd1);

        // Asynchronous reset mid-operation
        alloc_valid = 1'b1; alloc_req = 4'b1111;
        tick();
        reset = 1'b1;
        #1;
        chk("async_rst_overflow", 32'(overflow_err), 32'd0);
        chk("async_rst_count", 32'(free_count), 32'd224);
        chk("async_rst_tags", alloc_tags, 32'h23222120);
        reset = 1'b0;
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phys_free_list.md
Name: phys_free_list

Overview:
- Circular free list of physical register tags, feeding the rename/RAT stage.
- Supplies up to 4 free physical tags per cycle to rename, in fetch order.
- Takes released tags back from ROB retirement.
- Keeps a committed head pointer so a branch-mispredict flush restores the speculative allocation state in one cycle.

Parameters:
- NUM_PHYS, 256, number of physical registers; tag width is log2(NUM_PHYS) = 8.
- NUM_ARCH, 32, architectural registers; tags 0..NUM_ARCH-1 are mapped at reset.
- WIDTH, 4, rename, commit and free slots per cycle.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- alloc_valid  in  1  rename group present this cycle
- alloc_req  in  4  per-slot destination request; bit k = slot k (fetch order)
- alloc_tags  out  32  tag for slot k in [8k+7:8k]; zero for unrequested slots
- alloc_ready  out  1  free_count >= WIDTH
- commit_en  in  4  per retiring slot: instruction had allocated a destination
- free_en  in  4  per retiring slot: old mapping released
- free_tags  in  32  released tags, slot k in [8k+7:8k]
- bp_reset  in  1  mispredict flush
- free_count  out  9  tail - spec_head (speculatively free entries)
- overflow_err  out  1  sticky error flag

Behaviour:
- Storage: mem[0:NUM_PHYS-1] of 8-bit tags.
- Pointers: spec_head, commit_head, tail, all 8-bit and wrapping mod 256.
- Occupancy: free_count = tail - spec_head, computed 9-bit. All zero-extended pointer arithmetic is 9-bit.
- Reset (async):
  - mem[i] = NUM_ARCH+i for i = 0..223; mem[224..255] = 0.
  - spec_head = commit_head = 0; tail = 224.
  - free_count = 224, alloc_ready = 1, overflow_err = 0, alloc_tags = 0.
- Allocation (combinational output, registered update):
  - Slot k gets mem[spec_head + popcount(alloc_req[k-1:0])].
  - Tags are prefix-compacted across requesting slots, so no tag is skipped.
  - Fire = alloc_valid & alloc_ready & ~bp_reset.
  - On fire: spec_head += popcount(alloc_req) at the clock edge.
  - All-or-nothing: if alloc_ready = 0, nothing is allocated and rename stalls.
- Commit:
  - commit_head += popcount(commit_en) each cycle.
  - commit_head must never pass spec_head; if it would, overflow_err is set.
- Free:
  - Tags with free_en[k] are written at tail in slot order: mem[tail + popcount(free_en[k-1:0])].
  - tail += popcount(free_en).
  - Freed tags are visible to allocation from the next cycle only; no same-cycle bypass.
- Flush (bp_reset = 1):
  - Allocation is suppressed.
  - commit_en is applied first; then spec_head = the updated commit_head.
  - Free writes proceed normally in the same cycle.
  - free_count is correct on the following cycle.
- Overflow: if tail - commit_head + popcount(free_en) > NUM_PHYS - NUM_ARCH (224), overflow_err is set (sticky until reset) and the free writes still occur.
- Empty: free_count < 4 deasserts alloc_ready. With 0 free entries, alloc_tags contents are don't-care, but the spec_head update is blocked.
- Wrap-around: all pointers wrap 255 -> 0 naturally, with no extra state.
- Reset asserted mid-operation: all state returns to the reset values asynchronously. Outputs are valid from the first edge after deassertion.

Decomposition:
- Shared package (rename_pkg) holds:
  - constants NUM_PHYS, NUM_ARCH, WIDTH, TAG_W = 8;
  - typedef phys_tag_t (8-bit).
- The same package is used by regfile/RAT and the ROB.
- One sub-module: popcount_prefix. It takes a 4-bit mask and produces the 4 exclusive prefix counts (3-bit each) plus the total. It is instantiated for alloc_req, commit_en and free_en.

Test Plan:
- Reset, then alloc_valid = 1, alloc_req = 4'b1111 → alloc_tags = {35,34,33,32}; next cycle free_count = 220.
- From reset, alloc_req = 4'b1010 → slot1 = 32, slot3 = 33, slots 0 and 2 = 0; next cycle free_count = 222, and the next allocation starts at 34.
- Allocate 56 groups of 4 (224 tags) → free_count = 0, alloc_ready = 0, spec_head unchanged on further requests. Then free_en = 4'b0001 with tag 7 → next cycle free_count = 1, alloc_ready still 0.
- Allocate 8 tags (32..39), commit_en = 4'b0011 once (commit_head = 2), then bp_reset → next cycle spec_head = 2, free_count = 222, next alloc slot0 = 34.
- Drive tail across 255 → 0 with free_en = 4'b1111 of tags 0..3 after 224 allocations and 4 commits → mem[224..227] = 0..3; continued allocation returns 0,1,2,3 after tag 255.
- From reset (free list full), free_en = 4'b0001 → overflow_err = 1 next cycle and stays 1 until reset.
